// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control slice.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [4:0] ECALL_ARG_REG = 5'd17;
    localparam int         CNT_W_DEFAULT = 16;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating event counter with enable and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Stage enables, flush/bubble controls and data-cache handshake for the
// 5-stage core: freeze > mispredict > load-use/ecall > fetch bubble.
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_ecall,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_mispredict,
    input  logic             mem_access,
    output logic             dcache_req_valid,
    input  logic             dcache_resp_valid,
    input  logic             icache_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_e state_q;
    state_e state_d;

    logic freeze;
    logic load_use;
    logic ecall_dep;
    logic stall_en;
    logic flush_en;

    always_comb begin
        freeze = ((state_q == RUN) && mem_access) ||
                 ((state_q == WAIT) && !dcache_resp_valid);
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        ecall_dep = id_is_ecall && ex_reg_write &&
                    (ex_rd == ECALL_ARG_REG);
    end

    always_comb begin
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        id_ex_write      = 1'b1;
        ex_mem_write     = 1'b1;
        mem_wb_write     = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        mem_wb_bubble    = 1'b0;
        dcache_req_valid = (state_q == RUN) && mem_access;

        if (freeze) begin
            // EX is held, so a mispredict here waits until release
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use || ecall_dep) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!icache_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end

        if (!reset_n) begin
            pc_write         = 1'b0;
            if_id_write      = 1'b0;
            id_ex_write      = 1'b0;
            ex_mem_write     = 1'b0;
            mem_wb_write     = 1'b0;
            if_id_flush      = 1'b0;
            id_ex_flush      = 1'b0;
            mem_wb_bubble    = 1'b0;
            dcache_req_valid = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:  if (mem_access)        state_d = WAIT;
            WAIT: if (dcache_resp_valid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_en = reset_n && !pc_write;
    assign flush_en = if_id_flush || id_ex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (stall_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (flush_en),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: driver queues hand-computed control vectors, a
// negedge monitor pops and compares them against the live outputs.
module tb_hazard_stall_controller;

    localparam int CW = 4;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, bubble, req}
    localparam logic [8:0] NORM  = 9'b11111_000_0;
    localparam logic [8:0] FRZ   = 9'b00001_001_0;
    localparam logic [8:0] FRZR  = 9'b00001_001_1;
    localparam logic [8:0] MISP  = 9'b11111_110_0;
    localparam logic [8:0] STALL = 9'b00111_010_0;
    localparam logic [8:0] ICM   = 9'b01111_100_0;
    localparam logic [8:0] ZERO  = 9'b00000_000_0;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ecall;
        logic [4:0] exrd;
        logic       mrd;
        logic       rwr;
        logic       misp;
        logic       mem;
        logic       resp;
        logic       icr;
    } stim_t;

    typedef struct {
        logic [8:0] o;
        bit         chk;
        int         st;
        int         fl;
        string      name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, id_is_ecall;
    logic          ex_mem_read, ex_reg_write, ex_mispredict;
    logic          mem_access, dcache_resp_valid, icache_ready;
    logic          dcache_req_valid;
    logic          pc_write, if_id_write, id_ex_write;
    logic          ex_mem_write, mem_wb_write;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [CW-1:0] stall_cycles, flush_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    stim_t s;
    stim_t idle;

    always #5 clk = ~clk;

    hazard_stall_controller #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_use_rs1        (id_use_rs1),
        .id_use_rs2        (id_use_rs2),
        .id_is_ecall       (id_is_ecall),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .ex_reg_write      (ex_reg_write),
        .ex_mispredict     (ex_mispredict),
        .mem_access        (mem_access),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_resp_valid (dcache_resp_valid),
        .icache_ready      (icache_ready),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .id_ex_write       (id_ex_write),
        .ex_mem_write      (ex_mem_write),
        .mem_wb_write      (mem_wb_write),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .mem_wb_bubble     (mem_wb_bubble),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    task automatic apply(input stim_t v);
        reset_n           = v.rst_n;
        id_rs1            = v.rs1;
        id_rs2            = v.rs2;
        id_use_rs1        = v.use1;
        id_use_rs2        = v.use2;
        id_is_ecall       = v.ecall;
        ex_rd             = v.exrd;
        ex_mem_read       = v.mrd;
        ex_reg_write      = v.rwr;
        ex_mispredict     = v.misp;
        mem_access        = v.mem;
        dcache_resp_valid = v.resp;
        icache_ready      = v.icr;
    endtask

    task automatic step(input string nm, input logic [8:0] o,
                        input bit chk = 0, input int st = 0,
                        input int fl = 0);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.o = o; e.chk = chk; e.st = st; e.fl = fl; e.name = nm;
        sb.push_back(e);
        s = idle;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e = sb.pop_front();
            got = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   mem_wb_write, if_id_flush, id_ex_flush,
                   mem_wb_bubble, dcache_req_valid};
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL %s: ctrl got %b want %b", e.name, got, e.o);
            end
            if (e.chk) begin
                n_tests++;
                if (stall_cycles !== CW'(e.st) ||
                    flush_count !== CW'(e.fl)) begin
                    n_fail++;
                    $display("FAIL %s cnt: stall/flush got %0d/%0d want %0d/%0d",
                             e.name, stall_cycles, flush_count, e.st, e.fl);
                end
            end
        end
    end

    initial begin
        idle = '{rst_n: 1'b1, rs1: 5'd0, rs2: 5'd0, use1: 1'b0,
                 use2: 1'b0, ecall: 1'b0, exrd: 5'd0, mrd: 1'b0,
                 rwr: 1'b0, misp: 1'b0, mem: 1'b0, resp: 1'b0,
                 icr: 1'b1};
        s = idle;
        s.rst_n = 1'b0;
        apply(s);
        step("reset", ZERO, 1, 0, 0);
        step("idle", NORM, 1, 0, 0);

        // load-use on rs2
        s.mrd = 1; s.exrd = 5'd5; s.use2 = 1; s.rs2 = 5'd5;
        step("lu_rs2", STALL);
        step("lu_after", NORM, 1, 1, 1);
        s.mrd = 1; s.exrd = 5'd0; s.use2 = 1; s.rs2 = 5'd0;
        step("lu_x0", NORM);
        s.mrd = 1; s.exrd = 5'd7; s.use1 = 0; s.rs1 = 5'd7;
        step("lu_unused", NORM);
        s.mrd = 1; s.exrd = 5'd9; s.use1 = 1; s.rs1 = 5'd9;
        step("lu_rs1", STALL);

        // ecall x17 dependence
        s.ecall = 1; s.rwr = 1; s.exrd = 5'd17;
        step("ecall17", STALL);
        s.ecall = 1; s.rwr = 1; s.exrd = 5'd16;
        step("ecall16", NORM);
        s.ecall = 1; s.rwr = 0; s.exrd = 5'd17;
        step("ecall_nowr", NORM, 1, 3, 3);

        // miss with response 4 cycles late
        s.mem = 1;
        step("miss_req", FRZR);
        for (int i = 0; i < 4; i++) begin
            s.mem = 1;
            step("miss_wait", FRZ);
        end
        s.mem = 1; s.resp = 1;
        step("miss_resp", NORM);
        s.resp = 1;
        step("resp_in_run", NORM);

        // mispredict held throughout the miss
        s.mem = 1; s.misp = 1;
        step("mp_req", FRZR);
        for (int i = 0; i < 2; i++) begin
            s.mem = 1; s.misp = 1;
            step("mp_wait", FRZ);
        end
        s.mem = 1; s.misp = 1; s.resp = 1;
        step("mp_release", MISP);
        step("mp_after", NORM);

        // back-to-back accesses, each a fresh request
        s.mem = 1;
        step("b2b_req1", FRZR);
        s.mem = 1; s.resp = 1;
        step("b2b_resp1", NORM);
        s.mem = 1;
        step("b2b_req2", FRZR);
        s.mem = 1; s.resp = 1;
        step("b2b_resp2", NORM);

        // priority
        s.mrd = 1; s.exrd = 5'd5; s.use2 = 1; s.rs2 = 5'd5; s.icr = 0;
        step("lu_over_ic", STALL);
        s.icr = 0;
        step("icache_miss", ICM);
        s.mrd = 1; s.exrd = 5'd5; s.use2 = 1; s.rs2 = 5'd5; s.misp = 1;
        step("mp_over_lu", MISP);

        // reset in the middle of WAIT
        s.mem = 1;
        step("rst_req", FRZR);
        s.mem = 1;
        step("rst_wait", FRZ);
        s.mem = 1; s.rst_n = 0;
        step("rst_mid_wait", ZERO, 1, 0, 0);
        s.rst_n = 0;
        step("rst_hold", ZERO);
        step("rst_release", NORM, 1, 0, 0);

        // saturation: 20 fetch-stall cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            s.icr = 0;
            step("sat_ic", ICM);
        end
        step("sat_check", NORM, 1, 15, 15);
        step("sat_hold", NORM, 1, 15, 15);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left, want 0", sb.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline stall/flush controller for the 5-stage RISC-V core. It produces stage write-enables and bubble/flush controls that the forwarding path cannot resolve, and owns the data-cache request handshake for loads and stores in MEM. It covers:
- load-use hazards;
- ECALL x17 dependences on an EX-stage producer;
- data-cache miss freezes;
- branch-mispredict flushes;
- instruction-fetch bubbles.

It sits beside the ID-stage forwarding logic and drives every pipeline register.

## Interface
- CNT_W, 16, width of saturating performance counters
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5  ID-stage source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- id_is_ecall  in  1  ID instruction is ECALL (reads x17)
- ex_rd  in  5  ID/EX destination register
- ex_mem_read, ex_reg_write  in  1  ID/EX is a load / writes a register
- ex_mispredict  in  1  EX resolved a mispredicted branch or jump
- mem_access  in  1  EX/MEM holds a load or store
- dcache_req_valid  out  1  one-cycle request pulse to the data cache
- dcache_resp_valid  in  1  data cache completed the request
- icache_ready  in  1  fetch data valid this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  stage register enables
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1  load NOP into that register
- stall_cycles, flush_count  out  CNT_W  saturating statistics

## Operation
- FSM states:
  - RUN→WAIT when mem_access=1. dcache_req_valid=1 combinationally in that cycle only.
  - WAIT→RUN on dcache_resp_valid=1.
  - dcache_resp_valid in RUN is ignored.
- freeze = (RUN & mem_access) | (WAIT & !dcache_resp_valid).
- load_use = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- ecall_dep = id_is_ecall & ex_reg_write & ex_rd==17. This stalls because ECALL forwarding covers only MEM/WB producers.
- Control modes are resolved by strict priority, highest first. Every enable not listed is 1 and every flush not listed is 0.
  1. freeze: pc/if_id/id_ex/ex_mem write=0; mem_wb_write=1, mem_wb_bubble=1. ex_mispredict is ignored because EX is held, and is acted on after release.
  2. ex_mispredict: pc_write=1 (redirect), if_id_flush=1, id_ex_flush=1.
  3. load_use | ecall_dep: pc_write=0, if_id_write=0, id_ex_flush=1.
  4. !icache_ready: pc_write=0, if_id_flush=1.
  5. normal: all writes 1, no flushes.
- In the WAIT cycle where dcache_resp_valid=1:
  - freeze=0 and normal priorities 2–5 apply.
  - The access leaves MEM on this edge.
  - A mem_access seen in the next cycle is a new instruction.
- stall_cycles increments in every cycle with pc_write=0 while out of reset.
- flush_count increments in every cycle with id_ex_flush=1 or if_id_flush=1.
- Both counters saturate at all-ones.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=RUN, counters=0.
  - All enables, flushes, bubble and dcache_req_valid are forced 0 while reset_n=0.
- Outputs are combinational from state and inputs, with zero-cycle latency. State and counters update on the rising clk edge.
- Minimum memory access occupies MEM for 2 cycles: request cycle, then WAIT with response. An N-cycle-late response adds N freeze cycles.
- Back-to-back memory instructions each pay a fresh request. There is no pipelining of dcache requests.
- Load-use stall is exactly 1 cycle: the load moves to MEM and the dependence is then forwarded.
- Reset asserted in WAIT abandons the request; the cache is reset by the same reset_n.
- Counter saturation: at all-ones, further events hold the value.

## Structure
- pipeline_ctrl_pkg holds:
  - FSM state enum (RUN, WAIT);
  - the ECALL argument register constant (17);
  - default CNT_W.
- One sub-module, sat_counter (parameterised width, enable, async active-low reset), instantiated twice for the statistics.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs2=1, id_rs2=5 → 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Same stimulus with ex_rd=0 → no stall.
- ECALL dependence: id_is_ecall=1, ex_reg_write=1, ex_rd=17 → 1-cycle stall. With ex_rd=16 → no stall.
- Dcache miss: mem_access=1, dcache_resp_valid delayed 4 cycles → dcache_req_valid pulses once. Freeze lasts 5 cycles with mem_wb_bubble=1 throughout. The release cycle has ex_mem_write=1.
- Mispredict during a miss: ex_mispredict=1 throughout WAIT → no flush while frozen. The flush (if_id_flush=1, id_ex_flush=1) occurs in the response cycle.
- Priority: load_use and !icache_ready together → if_id_write=0, if_id_flush=0, id_ex_flush=1.
- Reset/saturation: assert reset_n=0 mid-WAIT → state RUN and all outputs 0 immediately. With CNT_W=4, 20 stall cycles → stall_cycles=15.
